// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Free-running VGA raster timing generator for the screensaver core.
// Produces the pixel coordinates, the active-video flag and the line/frame
// strobes for the pixel/colour logic. It also produces hsync/vsync through a
// PIPE_DELAY-deep register pipeline, so the syncs stay aligned with the core's
// registered RGB outputs.
//
// Optional feature: define VGA_TIMING_FRAME_COUNT_EN to get a completed-frame
// counter on frame_count. When the macro is undefined, frame_count is tied to 0.
//
// Ports:
//   clk_25_175   in   1        pixel clock
//   rst          in   1        asynchronous active-high reset
//   pixel_en     in   1        clock enable; counters/syncs advance only when high
//   x            out  10       horizontal position, 0..H_TOTAL-1
//   y            out  10       vertical position,   0..V_TOTAL-1
//   active       out  1        x < H_ACTIVE and y < V_ACTIVE (0 during reset)
//   line_start   out  1        x==0 on an enabled cycle
//   frame_start  out  1        line_start and y==0
//   hsync        out  1        horizontal sync, PIPE_DELAY enabled cycles late
//   vsync        out  1        vertical sync,   PIPE_DELAY enabled cycles late
//   frame_count  out  FRAME_W  completed-frame counter (0 if feature disabled)
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1,
    parameter int FRAME_W    = 8
) (
    input  logic               clk_25_175,
    input  logic               rst,
    input  logic               pixel_en,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync window bounds. Compared in 11 bits so a window ending exactly at
    // 1024 does not wrap to zero.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic SYNC_IDLE = ~SYNC_POL;

    logic [9:0]            r_x;
    logic [9:0]            r_y;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_hsync_raw;
    logic                  w_vsync_raw;
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;

    assign w_x_last = (r_x == 10'(H_TOTAL - 1));
    assign w_y_last = (r_y == 10'(V_TOTAL - 1));

    // Raster counters
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (pixel_en) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign x = r_x;
    assign y = r_y;

    // Decodes of the registered position. Strobes and active are gated by rst
    // so nothing downstream sees a spurious pixel while held in reset.
    assign active      = !rst && ({1'b0, r_x} < 11'(H_ACTIVE)) && ({1'b0, r_y} < 11'(V_ACTIVE));
    assign line_start  = !rst && pixel_en && (r_x == 10'd0);
    assign frame_start = line_start && (r_y == 10'd0);

    // Raw syncs already carry the configured polarity.
    assign w_hsync_raw = (({1'b0, r_x} >= 11'(H_SYNC_START)) && ({1'b0, r_x} < 11'(H_SYNC_END)))
                         ? SYNC_POL : SYNC_IDLE;
    assign w_vsync_raw = (({1'b0, r_y} >= 11'(V_SYNC_START)) && ({1'b0, r_y} < 11'(V_SYNC_END)))
                         ? SYNC_POL : SYNC_IDLE;

    // Sync delay line; advances together with the counters so the delay is
    // counted in pixels, not clocks.
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            r_hs_pipe <= {PIPE_DELAY{SYNC_IDLE}};
            r_vs_pipe <= {PIPE_DELAY{SYNC_IDLE}};
        end else if (pixel_en) begin
            r_hs_pipe[0] <= w_hsync_raw;
            r_vs_pipe[0] <= w_vsync_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
            end
        end
    end

    assign hsync = r_hs_pipe[PIPE_DELAY-1];
    assign vsync = r_vs_pipe[PIPE_DELAY-1];

`ifdef VGA_TIMING_FRAME_COUNT_EN
    // Counts frames that have fully completed (last pixel of last line taken).
    logic [FRAME_W-1:0] r_frame_count;

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (pixel_en && w_x_last && w_y_last) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

`ifndef SYNTHESIS
    // Counters are 10 bits wide and the sync delay line supports 1..4 stages.
    a_params_legal: assert property (@(posedge clk_25_175)
        (H_TOTAL <= 1024) && (V_TOTAL <= 1024) && (PIPE_DELAY >= 1) && (PIPE_DELAY <= 4))
        else $error("vga_timing: illegal parameter set");
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Two instances share clock, reset and pixel_en:
//   A: default 640x480 timing (first lines only, a full frame is too long)
//   B: tiny 15x10 raster, SYNC_POL=1, PIPE_DELAY=3, so many frames and the
//      frame_count wrap fit in a short run.
// A reference model derives every output from the number of enabled edges
// since reset (plain div/mod arithmetic) and is compared on every cycle.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    localparam int B_FRAME = 15 * 10;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_act, a_ls, a_fs, a_hs, a_vs;
    logic       b_act, b_ls, b_fs, b_hs, b_vs;
    logic [7:0] a_fc, b_fc;

    vga_timing u_a (
        .clk_25_175 (clk),   .rst        (rst),  .pixel_en    (en),
        .x          (a_x),   .y          (a_y),  .active      (a_act),
        .line_start (a_ls),  .frame_start(a_fs), .hsync       (a_hs),
        .vsync      (a_vs),  .frame_count(a_fc)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(3), .FRAME_W(8)
    ) u_b (
        .clk_25_175 (clk),   .rst        (rst),  .pixel_en    (en),
        .x          (b_x),   .y          (b_y),  .active      (b_act),
        .line_start (b_ls),  .frame_start(b_fs), .hsync       (b_hs),
        .vsync      (b_vs),  .frame_count(b_fc)
    );

    int      checks   = 0;
    int      failures = 0;
    longint  n        = 0;     // enabled edges since reset release
    bit      saw_wrap = 1'b0;
    logic [7:0] prev_bfc = 8'd0;

    task automatic finish_sim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (n=%0d t=%0t)", nm, act, exp, n, $time);
            if (failures >= 200) finish_sim();
        end
    endtask

    // Expected outputs follow from n alone: position is n mod raster size,
    // sync output shows the raw sync of the position PD enabled edges ago.
    task automatic model_check(input string nm,
                               input int ha, input int hf, input int hs, input int hb,
                               input int va, input int vf, input int vs, input int vb,
                               input bit pol, input int pd,
                               input logic [9:0] ax, input logic [9:0] ay,
                               input logic aact, input logic als, input logic afs,
                               input logic ahs, input logic avs, input logic [7:0] afc);
        int ht, vt;
        longint ex, ey, m, mx, my, e_fc;
        bit e_act, e_ls, e_fs, e_hs, e_vs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        e_hs = !pol;
        e_vs = !pol;
        if (rst) begin
            ex = 0; ey = 0; e_act = 0; e_ls = 0; e_fs = 0; e_fc = 0;
        end else begin
            ex    = n % ht;
            ey    = (n / ht) % vt;
            e_act = (ex < ha) && (ey < va);
            e_ls  = (ex == 0) && en;
            e_fs  = e_ls && (ey == 0);
            if (n >= pd) begin
                m  = n - pd;
                mx = m % ht;
                my = (m / ht) % vt;
                if (mx >= ha + hf && mx < ha + hf + hs) e_hs = pol;
                if (my >= va + vf && my < va + vf + vs) e_vs = pol;
            end
            e_fc = FC_EN ? (n / (ht * vt)) % 256 : 0;
        end
        cmp({nm, ".x"}, ax, ex);
        cmp({nm, ".y"}, ay, ey);
        cmp({nm, ".active"}, aact, e_act);
        cmp({nm, ".line_start"}, als, e_ls);
        cmp({nm, ".frame_start"}, afs, e_fs);
        cmp({nm, ".hsync"}, ahs, e_hs);
        cmp({nm, ".vsync"}, avs, e_vs);
        cmp({nm, ".frame_count"}, afc, e_fc);
    endtask

    // Compare process: inputs change just after posedge, so the negedge sees
    // settled outputs plus the pixel_en that the next posedge will use.
    always @(negedge clk) begin
        model_check("A", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1,
                    a_x, a_y, a_act, a_ls, a_fs, a_hs, a_vs, a_fc);
        model_check("B", 8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 3,
                    b_x, b_y, b_act, b_ls, b_fs, b_hs, b_vs, b_fc);
        if (!rst && prev_bfc == 8'd255 && b_fc == 8'd0) saw_wrap = 1'b1;
        prev_bfc = b_fc;
        if (rst)     n = 0;
        else if (en) n++;
    end

    initial begin
        int  lows;
        int  cyc;
        bit  found;

        // Reset, then full-rate run across A's first line
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        lows = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmp("A.first_line_start", a_ls, 1);
                cmp("A.first_frame_start", a_fs, 1);
                cmp("A.first_hsync_idle", a_hs, 1);
                cmp("A.first_vsync_idle", a_vs, 1);
                cmp("B.first_hsync_idle", b_hs, 0);
            end
            if (i < 800 && a_hs == 1'b0) lows++;
            if (i == 12)  cmp("B.hsync_before_rise", b_hs, 0);
            if (i == 13)  cmp("B.hsync_rise_3_late", b_hs, 1);
            if (i == 656) cmp("A.hsync_at_x656", a_hs, 1);
            if (i == 657) cmp("A.hsync_at_x657", a_hs, 0);
            if (i == 800) begin
                cmp("A.line2_line_start", a_ls, 1);
                cmp("A.line2_y", a_y, 1);
                cmp("A.line2_frame_start", a_fs, 0);
            end
        end
        cmp("A.hsync_low_width", lows, 96);

        // Half-rate enable
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1 en = (i % 2 == 0);
        end

        // Async reset while both of B's syncs are asserted
        @(posedge clk);
        #1 en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (b_y >= 10'd7 && b_y <= 10'd8 && b_x == 10'd13) found = 1'b1;
        end
        cmp("B.reached_sync_region", found, 1);
        cmp("B.pre_reset_hsync", b_hs, 1);
        cmp("B.pre_reset_vsync", b_vs, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        cmp("B.async_rst_x", b_x, 0);
        cmp("B.async_rst_y", b_y, 0);
        cmp("B.async_rst_hsync", b_hs, 0);
        cmp("B.async_rst_vsync", b_vs, 0);
        cmp("B.async_rst_line_start", b_ls, 0);
        cmp("A.async_rst_hsync", a_hs, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Random enable long enough for B's frame counter to wrap
        cyc = 0;
        while (n < 257 * B_FRAME + 20 && cyc < 70000) begin
            @(posedge clk);
            #1 en = ($urandom_range(0, 9) < 8);
            cyc++;
        end
        cmp("run_reached_frame_target", (n >= 257 * B_FRAME + 20), 1);
        cmp("B.frame_count_wrap_seen", saw_wrap, FC_EN);

        @(negedge clk);
        finish_sim();
    end

endmodule
